// File: rtl/cfg_word_loader_if.sv
// Word stream, control and latch-bank signals of the configuration word loader.
// The master drives words and control; the slave (loader) drives the latch bus and status.
interface cfg_word_loader_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 18,
    parameter int IDX_W     = 5
);
    logic                 start;
    logic                 abort;
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_W-1:0]    in_data;
    logic [WORD_W-1:0]    d_out;
    logic [NUM_WORDS-1:0] configs_en;
    logic [IDX_W-1:0]     word_idx;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, d_out, configs_en, word_idx, busy, done
    );

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, d_out, configs_en, word_idx, busy, done
    );
endinterface

// File: rtl/cfg_word_loader.sv
// Write-side sequencer for the configuration latch bank: takes one word per slot and
// walks it through setup, enable strobe and hold so each transparent latch sees stable data.
//
// state     | meaning
// IDLE      | no pass in progress (after reset or abort)
// WAIT_WORD | ready for the word of slot word_idx
// SETUP     | data bus settled, enables low
// STROBE    | one-hot enable of slot word_idx high for STROBE_CYCLES cycles
// HOLD      | enables low, data held; advance slot or finish
// DONE      | all slots written, done is sticky
module cfg_word_loader #(
    parameter int WORD_W        = 32,
    parameter int NUM_WORDS     = 18,
    parameter int IDX_W         = 5,
    parameter int STROBE_CYCLES = 1
) (
    input logic               clk,
    input logic               reset,
    cfg_word_loader_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(NUM_WORDS - 1);
    localparam logic [3:0]           STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [NUM_WORDS-1:0] EN_LSB      = NUM_WORDS'(1);

    state_t               state, state_nxt;
    logic [3:0]           strobe_cnt, strobe_cnt_nxt;
    logic                 abort_pend, abort_pend_nxt;
    logic [WORD_W-1:0]    d_out_r, d_out_nxt;
    logic [NUM_WORDS-1:0] en_r, en_nxt;
    logic [IDX_W-1:0]     idx_r, idx_nxt;
    logic                 ready_r, ready_nxt;
    logic                 busy_r, busy_nxt;
    logic                 done_r, done_nxt;

    // Every output is a flop so the latch enables never glitch while the index changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            strobe_cnt <= '0;
            abort_pend <= 1'b0;
            d_out_r    <= '0;
            en_r       <= '0;
            idx_r      <= '0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_nxt;
            strobe_cnt <= strobe_cnt_nxt;
            abort_pend <= abort_pend_nxt;
            d_out_r    <= d_out_nxt;
            en_r       <= en_nxt;
            idx_r      <= idx_nxt;
            ready_r    <= ready_nxt;
            busy_r     <= busy_nxt;
            done_r     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        strobe_cnt_nxt = strobe_cnt;
        abort_pend_nxt = abort_pend;
        d_out_nxt      = d_out_r;
        en_nxt         = '0;
        idx_nxt        = idx_r;
        ready_nxt      = 1'b0;
        busy_nxt       = busy_r;
        done_nxt       = done_r;

        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nxt      = WAIT_WORD;
                    idx_nxt        = '0;
                    done_nxt       = 1'b0;
                    ready_nxt      = 1'b1;
                    busy_nxt       = 1'b1;
                    abort_pend_nxt = 1'b0;
                end
            end
            WAIT_WORD: begin
                ready_nxt = 1'b1;
                if (bus.abort) begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                end else if (bus.in_valid && ready_r) begin
                    d_out_nxt = bus.in_data;
                    state_nxt = SETUP;
                    ready_nxt = 1'b0;
                end
            end
            SETUP: begin
                abort_pend_nxt = abort_pend | bus.abort;
                en_nxt         = EN_LSB << idx_r;
                strobe_cnt_nxt = STROBE_LOAD;
                state_nxt      = STROBE;
            end
            STROBE: begin
                abort_pend_nxt = abort_pend | bus.abort;
                if (strobe_cnt == 4'd0) begin
                    state_nxt = HOLD;
                end else begin
                    strobe_cnt_nxt = strobe_cnt - 4'd1;
                    en_nxt         = en_r;
                end
            end
            HOLD: begin
                busy_nxt       = 1'b0;
                abort_pend_nxt = 1'b0;
                // The last slot completes the pass even if an abort is pending.
                if (idx_r == LAST_IDX) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (abort_pend || bus.abort) begin
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx_r + 1'b1;
                    state_nxt = WAIT_WORD;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.in_ready   = ready_r;
    assign bus.d_out      = d_out_r;
    assign bus.configs_en = en_r;
    assign bus.word_idx   = idx_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_cfg_word_loader.sv
// Bench for cfg_word_loader: a cycle-level pass model predicts status and queues each
// accepted word; a monitor pops the queue whenever a latch strobe appears.
module tb_cfg_word_loader;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 18;
    localparam int IDX_W     = 5;
    localparam int S1        = 1;
    localparam int S3        = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cfg_word_loader_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) bus1 ();
    cfg_word_loader_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) bus3 ();

    cfg_word_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W), .STROBE_CYCLES(S1))
        dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    cfg_word_loader #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W), .STROBE_CYCLES(S3))
        dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_WORDS-1:0] onehot(input int s);
        logic [NUM_WORDS-1:0] v;
        v = '0;
        if (s >= 0 && s < NUM_WORDS) v[s] = 1'b1;
        return v;
    endfunction

    typedef struct {
        int               slot;
        logic [WORD_W-1:0] data;
        int               at;
    } exp_t;
    exp_t exp_q[$];

    // Pass model: a pass is alive from start+1 until its end cycle; words occupy 3+S cycles.
    bit m_active = 0;
    int m_start = 0, m_free = 0, m_end = -1, m_slot = 0, m_done_from = -1;

    always @(negedge clk) begin : model
        int c;
        bit busy_e, ready_e, done_e;
        exp_t e;
        c = cyc;
        if (reset) begin
            m_active = 0;
            m_end = -1;
            m_done_from = -1;
            exp_q.delete();
        end else begin
            busy_e  = m_active && (c > m_start) && (m_end < 0 || c < m_end);
            ready_e = busy_e && (c >= m_free);
            done_e  = (m_done_from >= 0) && (c >= m_done_from);
            check("busy", bus1.busy, busy_e);
            check("ready", bus1.in_ready, ready_e);
            check("done", bus1.done, done_e);
            if (busy_e) check("word_idx", bus1.word_idx, (c < m_free) ? m_slot - 1 : m_slot);
            if (bus1.start && !busy_e) begin
                m_active = 1;
                m_start = c;
                m_free = c + 1;
                m_end = -1;
                m_slot = 0;
                m_done_from = -1;
            end else if (busy_e && bus1.abort) begin
                if (m_end < 0) m_end = (c < m_free) ? m_free : c + 1;
            end else if (ready_e && bus1.in_valid) begin
                e.slot = m_slot;
                e.data = bus1.in_data;
                e.at = c + 2;
                exp_q.push_back(e);
                m_slot++;
                m_free = c + 3 + S1;
                if (m_slot == NUM_WORDS) begin
                    m_end = m_free;
                    m_done_from = m_free;
                end
            end
        end
    end

    exp_t cur;
    int hi_cnt = 0;
    logic [NUM_WORDS-1:0] prev_en = '0;
    logic [WORD_W-1:0] prev_d = '0;

    always @(negedge clk) begin : monitor
        if (reset) begin
            hi_cnt = 0;
            prev_en = '0;
            prev_d = '0;
        end else begin
            if (bus1.configs_en != '0) begin
                if (prev_en == '0) begin
                    check("strobe_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check("strobe_cycle", cyc, cur.at);
                        check("setup_data", prev_d, cur.data);
                    end else begin
                        cur.slot = -1;
                    end
                    hi_cnt = 0;
                end
                hi_cnt++;
                check("en_onehot", bus1.configs_en, onehot(cur.slot));
                check("strobe_data", bus1.d_out, cur.data);
            end else if (prev_en != '0) begin
                check("strobe_len", hi_cnt, S1);
                check("hold_data", bus1.d_out, cur.data);
            end
            prev_en = bus1.configs_en;
            prev_d = bus1.d_out;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(output bit acc);
        @(negedge clk);
        acc = bus1.in_valid && bus1.in_ready && !bus1.abort;
        @(posedge clk);
        #1;
    endtask

    task automatic feed_word(input logic [WORD_W-1:0] w, input bit gaps, output bit ok);
        int g;
        bit acc;
        g = 0;
        acc = 0;
        bus1.in_data = w;
        while (!acc && g < 60) begin
            bus1.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            step(acc);
            g++;
        end
        ok = acc;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, bus1.configs_en, 0);
        check({tag, "_dout"}, bus1.d_out, 0);
        check({tag, "_idx"}, bus1.word_idx, 0);
        check({tag, "_ready"}, bus1.in_ready, 0);
        check({tag, "_busy"}, bus1.busy, 0);
        check({tag, "_done"}, bus1.done, 0);
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (!bus1.done && g < 300) begin
            tick();
            g++;
        end
        check(tag, bus1.done, 1);
    endtask

    initial begin
        bit acc, ok;
        int base, g, k3;
        logic [WORD_W-1:0] w, last_word;

        bus1.start = 0; bus1.abort = 0; bus1.in_valid = 0; bus1.in_data = '0;
        bus3.start = 0; bus3.abort = 0; bus3.in_valid = 0; bus3.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset3_en", bus3.configs_en, 0);
        reset = 0;
        tick();

        // Full pass, valid always high, fixed words.
        bus1.start = 1;
        base = cyc;
        step(acc);
        bus1.start = 0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            feed_word(32'hA000_0000 + WORD_W'(k), 1'b0, ok);
            check("full_accept", ok, 1);
        end
        bus1.in_valid = 0;
        while (cyc < base + 72) tick();
        check("full_done_72", bus1.done, 0);
        tick();
        check("full_done_73", bus1.done, 1);
        check("full_busy_73", bus1.busy, 0);
        check("full_dout_kept", bus1.d_out, 32'hA000_0011);

        // Stall before word 3, ignored start while busy, random tail.
        bus1.start = 1;
        step(acc);
        bus1.start = 0;
        for (int k = 0; k < 3; k++) begin
            feed_word($urandom, 1'b0, ok);
            check("stall_pre_accept", ok, 1);
        end
        bus1.in_valid = 0;
        bus1.start = 1;
        tick();
        bus1.start = 0;
        check("start_ignored_idx", bus1.word_idx, 2);
        g = 0;
        while (!bus1.in_ready && g < 20) begin
            tick();
            g++;
        end
        check("stall_reach_wait", bus1.in_ready, 1);
        repeat (5) begin
            check("stall_en", bus1.configs_en, 0);
            check("stall_idx", bus1.word_idx, 3);
            tick();
        end
        w = $urandom;
        feed_word(w, 1'b0, ok);
        check("stall_w3_accept", ok, 1);
        bus1.in_valid = 0;
        tick();
        check("w3_strobe_en", bus1.configs_en, onehot(3));
        check("w3_strobe_data", bus1.d_out, w);
        for (int k = 4; k < NUM_WORDS; k++) begin
            last_word = $urandom;
            feed_word(last_word, 1'b1, ok);
            check("rand_accept", ok, 1);
        end
        bus1.in_valid = 0;
        wait_done("stall_pass_done");

        // Restart from DONE, then abort in WAIT_WORD with a valid word offered.
        bus1.start = 1;
        tick();
        bus1.start = 0;
        check("restart_done_clr", bus1.done, 0);
        check("restart_idx", bus1.word_idx, 0);
        check("restart_ready", bus1.in_ready, 1);
        bus1.in_valid = 1;
        bus1.in_data = $urandom;
        bus1.abort = 1;
        tick();
        bus1.abort = 0;
        bus1.in_valid = 0;
        check("abort_wait_busy", bus1.busy, 0);
        check("abort_wait_ready", bus1.in_ready, 0);
        check("abort_wait_dout", bus1.d_out, last_word);
        repeat (4) tick();
        check("abort_wait_en", bus1.configs_en, 0);

        // Reset in the middle of word 9's strobe, then a clean reload.
        bus1.start = 1;
        step(acc);
        bus1.start = 0;
        for (int k = 0; k < 10; k++) begin
            feed_word($urandom, 1'b1, ok);
            check("pre_reset_accept", ok, 1);
        end
        bus1.in_valid = 0;
        g = 0;
        while (bus1.configs_en == '0 && g < 20) begin
            tick();
            g++;
        end
        check("w9_strobe_seen", bus1.configs_en, onehot(9));
        #2 reset = 1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;
        tick();
        bus1.start = 1;
        step(acc);
        bus1.start = 0;
        check("reload_idx", bus1.word_idx, 0);
        for (int k = 0; k < NUM_WORDS; k++) begin
            feed_word($urandom, 1'b1, ok);
            check("reload_accept", ok, 1);
        end
        bus1.in_valid = 0;
        wait_done("reload_done");

        // Abort during word 5's strobe with a 3-cycle enable.
        bus3.start = 1;
        tick();
        bus3.start = 0;
        bus3.in_valid = 1;
        k3 = 0;
        g = 0;
        while (!bus3.configs_en[5] && g < 200) begin
            bus3.in_data = 32'h5A5A_0000 ^ WORD_W'(k3);
            @(negedge clk);
            if (bus3.in_valid && bus3.in_ready) k3++;
            @(posedge clk);
            #1;
            g++;
        end
        bus3.in_valid = 0;
        check("s3_strobe1_en", bus3.configs_en, onehot(5));
        check("s3_strobe_data", bus3.d_out, 32'h5A5A_0005);
        bus3.abort = 1;
        tick();
        bus3.abort = 0;
        check("s3_strobe2_en", bus3.configs_en, onehot(5));
        tick();
        check("s3_strobe3_en", bus3.configs_en, onehot(5));
        tick();
        check("s3_hold_en", bus3.configs_en, 0);
        check("s3_hold_busy", bus3.busy, 1);
        tick();
        check("s3_abort_busy", bus3.busy, 0);
        check("s3_abort_done", bus3.done, 0);
        check("s3_abort_ready", bus3.in_ready, 0);
        check("s3_abort_idx", bus3.word_idx, 5);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
